match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
- Match-flow controller for the Pong game. It consumes ball_x from the ball stage plus the debounced/one-pulsed enter button.
- Outputs:
  - game phase
  - per-player scores
  - match countdown
  - the new_round pulse that re-serves the ball
  - game_over / winner flags consumed by display_text and pixel_gen
- Replaces the ad-hoc score/timer/state logic in the top level with one single-clock FSM.

Parameters:
- CLK_HZ, 100000000, clk cycles per match-timer second.
- WIN_SCORE, 5, points that end the match (1..15).
- MATCH_SECONDS, 60, countdown start value (1..63).
- OVER_HOLD_SEC, 3, seconds the OVER screen is held before returning to READY (1..15).
- SERVE_FRAMES, 30, refresh_tick pulses the ball is held before play resumes (1..255).
- RIGHT_EDGE, 640, ball_x value at or above which player 1 scores.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- enter_pulse  in  1  one-cycle start request.
- refresh_tick  in  1  one-cycle per-frame pulse.
- ball_x  in  10  ball left coordinate.
- state  out  2  0 READY, 1 SERVE, 2 PLAY, 3 OVER.
- new_round  out  1  one-cycle pulse; ball module resets on it.
- ball_hold  out  1  high in SERVE; ball frozen at centre.
- score1  out  4  player 1 points.
- score2  out  4  player 2 points.
- seconds  out  6  remaining match seconds.
- game_over  out  1  high in OVER.
- winner  out  2  01 P1, 10 P2, 11 draw, 00 none.

Behaviour:
- Reset (async, immediate) values:
  - state = READY
  - score1 = score2 = 0
  - seconds = MATCH_SECONDS
  - new_round = 0, ball_hold = 0, game_over = 0, winner = 00
  - prescaler = 0, frame counter = 0, hold counter = 0
- Every cycle while state == READY: clear scores, seconds, prescaler and winner.
- Prescaler:
  - Counts clk only in SERVE, PLAY and OVER.
  - Wraps at CLK_HZ-1, producing a one-cycle sec_tick.
  - Cleared on entry to SERVE-from-READY and on entry to OVER.
- READY:
  - enter_pulse -> SERVE next cycle; new_round = 1 for exactly that one cycle.
  - All other inputs ignored.
- SERVE:
  - ball_hold = 1; the frame counter counts refresh_tick.
  - After SERVE_FRAMES ticks -> PLAY.
  - sec_tick decrements seconds (the timer keeps running during serve).
  - Ball position ignored.
- PLAY:
  - ball_x == 0 -> score2 += 1.
  - ball_x >= RIGHT_EDGE -> score1 += 1.
  - Only one goal is registered per rally: the FSM leaves PLAY the cycle after detection, so a ball lingering off-screen never double-scores.
  - After a goal:
    - If the new score == WIN_SCORE -> OVER.
    - Else -> SERVE with a one-cycle new_round pulse; frame counter cleared.
  - sec_tick decrements seconds. When seconds goes 1 -> 0 -> OVER.
- Seconds saturate at 0 and never wrap.
- Goal and seconds-expiry in the same cycle: the goal is counted first, then the state goes to OVER (no new_round pulse).
- OVER:
  - game_over = 1; winner latched on entry from the final scores: higher score wins, equal scores give 11.
  - sec_tick counts the hold counter; at OVER_HOLD_SEC -> READY.
  - enter_pulse ignored.
- Scores never exceed WIN_SCORE (WIN_SCORE ≤ 15 guarantees 4-bit scores never wrap).
- new_round is 0 in all cycles except those stated above. It is never asserted together with reset.
- All outputs are registered; latency from input event to output change is 1 clk.

Test Plan:
Bench parameters: CLK_HZ=10, MATCH_SECONDS=5, WIN_SCORE=2, SERVE_FRAMES=2, OVER_HOLD_SEC=2.
- Reset, then enter_pulse -> state 0->1 next cycle, new_round high exactly 1 cycle; after 2 refresh_ticks state = 2.
- In PLAY, hold ball_x = 0 for 5 cycles -> score2 = 1 (not 5), state = 1, one new_round pulse.
- Two P1 goals (ball_x = 700) -> score1 = 2, state = 3, game_over = 1, winner = 01; after 20 clk state = 0, scores = 0, seconds = 5.
- No goals for 50 clk -> seconds 5->0 at 10-clk steps, state = 3, winner = 11 (0:0 draw).
- Goal coincident with the final sec_tick at 1:0 -> score becomes 2:0, state = 3, new_round stays 0.
- Assert reset mid-PLAY, off any clk edge -> all outputs take their reset values immediately; enter_pulse during OVER -> no effect.

Source files
------------

// File: rtl/match_ctrl_if.sv
// Bundle between the Pong match controller and the rest of the game.
// Carries the ball/button inputs and the phase, score and timer outputs.
interface match_ctrl_if;
  logic       enter_pulse;
  logic       refresh_tick;
  logic [9:0] ball_x;
  logic [1:0] state;
  logic       new_round;
  logic       ball_hold;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [5:0] seconds;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output enter_pulse, refresh_tick, ball_x,
    input  state, new_round, ball_hold, score1, score2, seconds, game_over, winner
  );

  modport slave (
    input  enter_pulse, refresh_tick, ball_x,
    output state, new_round, ball_hold, score1, score2, seconds, game_over, winner
  );
endinterface

// File: rtl/match_ctrl.sv
// Pong match-flow FSM: READY -> SERVE -> PLAY -> OVER, with scores,
// match countdown, serve hold and winner decode in one clock domain.
module match_ctrl #(
  parameter int CLK_HZ        = 100000000,
  parameter int WIN_SCORE     = 5,
  parameter int MATCH_SECONDS = 60,
  parameter int OVER_HOLD_SEC = 3,
  parameter int SERVE_FRAMES  = 30,
  parameter int RIGHT_EDGE    = 640
) (
  input  logic         clk,
  input  logic         reset,
  match_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [5:0]    SEC_INIT = 6'(MATCH_SECONDS);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
  localparam logic [3:0]    HOLD     = 4'(OVER_HOLD_SEC);
  localparam logic [7:0]    FRAMES   = 8'(SERVE_FRAMES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    score1_q, score1_d, score2_q, score2_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          new_round_q, new_round_d;
  logic [1:0]    winner_q, winner_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [7:0]    frame_q, frame_d;
  logic [3:0]    hold_q, hold_d;

  logic sec_tick, goal1, goal2, expire, win_goal, enter_over;

  always_comb begin
    sec_tick = (state_q != ST_READY) && (prescaler_q == PRE_MAX);
    goal1    = (state_q == ST_PLAY) && (32'(bus.ball_x) >= RIGHT_EDGE);
    goal2    = (state_q == ST_PLAY) && (bus.ball_x == 10'd0);
    expire   = sec_tick && (seconds_q == 6'd1);
    win_goal = (goal1 && (score1_q + 4'd1 == WIN)) || (goal2 && (score2_q + 4'd1 == WIN));

    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    seconds_d   = seconds_q;
    new_round_d = 1'b0;
    winner_d    = winner_q;
    frame_d     = frame_q;
    hold_d      = hold_q;

    if (sec_tick && (seconds_q != 6'd0) &&
        ((state_q == ST_SERVE) || (state_q == ST_PLAY)))
      seconds_d = seconds_q - 6'd1;

    case (state_q)
      ST_READY: begin
        if (bus.enter_pulse) begin
          state_d     = ST_SERVE;
          new_round_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (bus.refresh_tick) begin
          frame_d = frame_q + 8'd1;
          if (frame_q + 8'd1 == FRAMES)
            state_d = ST_PLAY;
        end
        // The clock runs during serve, so expiry must end the match here too.
        if (expire)
          state_d = ST_OVER;
      end
      ST_PLAY: begin
        if (goal1) score1_d = score1_q + 4'd1;
        if (goal2) score2_d = score2_q + 4'd1;
        if (win_goal || expire)
          state_d = ST_OVER;
        else if (goal1 || goal2) begin
          state_d     = ST_SERVE;
          new_round_d = 1'b1;
        end
      end
      default: begin
        if (sec_tick) begin
          hold_d = hold_q + 4'd1;
          if (hold_q + 4'd1 == HOLD)
            state_d = ST_READY;
        end
      end
    endcase

    enter_over = (state_d == ST_OVER) && (state_q != ST_OVER);

    if ((state_d == ST_SERVE) && (state_q != ST_SERVE))
      frame_d = 8'd0;

    if (enter_over) begin
      hold_d = 4'd0;
      if (score1_d > score2_d)      winner_d = 2'b01;
      else if (score2_d > score1_d) winner_d = 2'b10;
      else                          winner_d = 2'b11;
    end

    if ((state_d == ST_READY) || (state_q == ST_READY) || enter_over || sec_tick)
      prescaler_d = '0;
    else
      prescaler_d = prescaler_q + PW'(1);

    // Clearing on the way into READY keeps stale scores off the idle screen.
    if (state_d == ST_READY) begin
      score1_d  = 4'd0;
      score2_d  = 4'd0;
      seconds_d = SEC_INIT;
      winner_d  = 2'b00;
      frame_d   = 8'd0;
      hold_d    = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_READY;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      seconds_q   <= SEC_INIT;
      new_round_q <= 1'b0;
      winner_q    <= 2'b00;
      prescaler_q <= '0;
      frame_q     <= 8'd0;
      hold_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      seconds_q   <= seconds_d;
      new_round_q <= new_round_d;
      winner_q    <= winner_d;
      prescaler_q <= prescaler_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.new_round = new_round_q;
  assign bus.ball_hold = (state_q == ST_SERVE);
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.seconds   = seconds_q;
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl with short timing parameters
// (10 clk per second, 5 s match, first to 2, 2-frame serve, 2 s hold).
module tb_match_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compare_count = 0;
  int fail_count = 0;
  int pulse_count;

  match_ctrl_if u_if ();

  match_ctrl #(
    .CLK_HZ(10), .WIN_SCORE(2), .MATCH_SECONDS(5),
    .OVER_HOLD_SEC(2), .SERVE_FRAMES(2), .RIGHT_EDGE(640)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_state"},     32'(u_if.state), 0);
    check_output({tag, "_score1"},    32'(u_if.score1), 0);
    check_output({tag, "_score2"},    32'(u_if.score2), 0);
    check_output({tag, "_seconds"},   32'(u_if.seconds), 5);
    check_output({tag, "_new_round"}, 32'(u_if.new_round), 0);
    check_output({tag, "_ball_hold"}, 32'(u_if.ball_hold), 0);
    check_output({tag, "_game_over"}, 32'(u_if.game_over), 0);
    check_output({tag, "_winner"},    32'(u_if.winner), 0);
  endtask

  task automatic serve_to_play();
    u_if.refresh_tick = 1'b1;
    tick(2);
    u_if.refresh_tick = 1'b0;
  endtask

  task automatic start_match();
    u_if.enter_pulse = 1'b1;
    tick(1);
    u_if.enter_pulse = 1'b0;
    serve_to_play();
  endtask

  initial begin
    u_if.enter_pulse  = 1'b0;
    u_if.refresh_tick = 1'b0;
    u_if.ball_x       = 10'd320;

    #12;
    check_reset_values("reset");
    reset = 1'b0;
    tick(1);
    check_output("idle_state", 32'(u_if.state), 0);

    $display("[TB] start, serve and play");
    u_if.enter_pulse = 1'b1;
    tick(1);
    u_if.enter_pulse = 1'b0;
    check_output("start_state", 32'(u_if.state), 1);
    check_output("start_new_round", 32'(u_if.new_round), 1);
    check_output("start_ball_hold", 32'(u_if.ball_hold), 1);
    tick(1);
    check_output("start_pulse_end", 32'(u_if.new_round), 0);
    serve_to_play();
    check_output("serve_done_state", 32'(u_if.state), 2);
    check_output("serve_done_hold", 32'(u_if.ball_hold), 0);

    $display("[TB] ball lingering at left edge");
    u_if.ball_x = 10'd0;
    pulse_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (u_if.new_round === 1'b1) pulse_count++;
    end
    u_if.ball_x = 10'd320;
    check_output("linger_score2", 32'(u_if.score2), 1);
    check_output("linger_score1", 32'(u_if.score1), 0);
    check_output("linger_state", 32'(u_if.state), 1);
    check_output("linger_pulses", 32'(pulse_count), 1);

    $display("[TB] two P1 goals win the match");
    serve_to_play();
    u_if.ball_x = 10'd700;
    tick(1);
    u_if.ball_x = 10'd320;
    check_output("p1_goal1_score", 32'(u_if.score1), 1);
    check_output("p1_goal1_state", 32'(u_if.state), 1);
    check_output("p1_goal1_pulse", 32'(u_if.new_round), 1);
    serve_to_play();
    u_if.ball_x = 10'd700;
    tick(1);
    u_if.ball_x = 10'd320;
    check_output("p1_win_score1", 32'(u_if.score1), 2);
    check_output("p1_win_state", 32'(u_if.state), 3);
    check_output("p1_win_game_over", 32'(u_if.game_over), 1);
    check_output("p1_win_winner", 32'(u_if.winner), 1);
    check_output("p1_win_no_pulse", 32'(u_if.new_round), 0);
    tick(5);
    u_if.enter_pulse = 1'b1;
    tick(1);
    u_if.enter_pulse = 1'b0;
    check_output("over_enter_state", 32'(u_if.state), 3);
    check_output("over_enter_pulse", 32'(u_if.new_round), 0);
    tick(13);
    check_output("over_hold_19", 32'(u_if.state), 3);
    tick(1);
    check_output("over_done_state", 32'(u_if.state), 0);
    check_output("over_done_score1", 32'(u_if.score1), 0);
    check_output("over_done_score2", 32'(u_if.score2), 0);
    check_output("over_done_seconds", 32'(u_if.seconds), 5);
    check_output("over_done_winner", 32'(u_if.winner), 0);
    check_output("over_done_game_over", 32'(u_if.game_over), 0);

    $display("[TB] timeout draw");
    start_match();
    tick(7);
    check_output("draw_sec_pre", 32'(u_if.seconds), 5);
    tick(1);
    check_output("draw_sec_first", 32'(u_if.seconds), 4);
    for (int i = 1; i <= 3; i++) begin
      tick(10);
      check_output("draw_sec_step", 32'(u_if.seconds), 32'(4 - i));
    end
    tick(9);
    check_output("draw_last_sec", 32'(u_if.seconds), 1);
    check_output("draw_still_play", 32'(u_if.state), 2);
    tick(1);
    check_output("draw_sec_zero", 32'(u_if.seconds), 0);
    check_output("draw_state", 32'(u_if.state), 3);
    check_output("draw_winner", 32'(u_if.winner), 3);
    tick(20);
    check_output("draw_back_ready", 32'(u_if.state), 0);

    $display("[TB] winning goal on final second");
    start_match();
    u_if.ball_x = 10'd700;
    tick(1);
    u_if.ball_x = 10'd320;
    serve_to_play();
    tick(44);
    check_output("final_pre_sec", 32'(u_if.seconds), 1);
    check_output("final_pre_state", 32'(u_if.state), 2);
    u_if.ball_x = 10'd700;
    tick(1);
    u_if.ball_x = 10'd320;
    check_output("final_score1", 32'(u_if.score1), 2);
    check_output("final_score2", 32'(u_if.score2), 0);
    check_output("final_sec", 32'(u_if.seconds), 0);
    check_output("final_state", 32'(u_if.state), 3);
    check_output("final_no_pulse", 32'(u_if.new_round), 0);
    tick(20);

    $display("[TB] non-winning goal on final second");
    start_match();
    tick(47);
    check_output("expiry_pre_sec", 32'(u_if.seconds), 1);
    u_if.ball_x = 10'd0;
    tick(1);
    u_if.ball_x = 10'd320;
    check_output("expiry_score2", 32'(u_if.score2), 1);
    check_output("expiry_state", 32'(u_if.state), 3);
    check_output("expiry_no_pulse", 32'(u_if.new_round), 0);
    check_output("expiry_winner", 32'(u_if.winner), 2);
    tick(20);

    $display("[TB] reset mid-play");
    start_match();
    u_if.ball_x = 10'd700;
    tick(1);
    u_if.ball_x = 10'd320;
    serve_to_play();
    check_output("pre_reset_state", 32'(u_if.state), 2);
    check_output("pre_reset_score1", 32'(u_if.score1), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    #2;
    reset = 1'b0;
    tick(1);
    check_output("post_reset_state", 32'(u_if.state), 0);
    check_output("post_reset_pulse", 32'(u_if.new_round), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end
endmodule
